// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: 15-entry register file, sticky status/halt, retired counter.
// Optional same-cycle write-to-read forwarding is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int          CNT_W    = 32,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [3:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [3:0] SBUB  = 4'd0;
    localparam logic [3:0] SAOK  = 4'd1;
    localparam logic [3:0] SHLT  = 4'd2;
    localparam logic [3:0] SADR  = 4'd3;
    localparam logic [3:0] SINS  = 4'd4;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    logic [63:0] regs [0:14];

    logic       wr_ok;
    logic       is_fault;
    logic [3:0] fault_code;
    logic       retire;

    // Reset gates wr_ok so a write pending while rst is high is neither committed nor forwarded.
    assign wr_ok      = ((W_stat == SAOK) || (W_stat == SBUB)) && !halted && !rst;
    assign is_fault   = (W_stat != SAOK) && (W_stat != SBUB);
    assign fault_code = (W_stat > SINS) ? SINS : W_stat;
    assign retire     = !halted && (W_stat != SBUB) && !((W_stat == SAOK) && (W_icode == INOP));

    // NOTE: the register file is reset like any other state, so it maps to flops rather
    // than a RAM macro; %rsp gets its own reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
            end
            Stat        <= SAOK;
            halted      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments; when dstE == dstM the later valM write wins.
            if (wr_ok) begin
                if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
                if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
            end
            if (!halted && is_fault) begin
                Stat   <= fault_code;
                halted <= 1'b1;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

    // NOTE: every output of this block is assigned up front, so no latch can be inferred.
    always_comb begin
        d_rvalA = (d_srcA == RNONE) ? 64'h0 : regs[d_srcA];
        d_rvalB = (d_srcB == RNONE) ? 64'h0 : regs[d_srcB];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_ok && (d_srcA != RNONE)) begin
            if (d_srcA == W_dstM)      d_rvalA = W_valM;
            else if (d_srcA == W_dstE) d_rvalA = W_valE;
        end
        if (wr_ok && (d_srcB != RNONE)) begin
            if (d_srcB == W_dstM)      d_rvalB = W_valM;
            else if (d_srcB == W_dstE) d_rvalB = W_valE;
        end
`endif
    end

endmodule
